// File: rtl/dcpu16_opfetch.sv
// dcpu16_opfetch: sequences NOPS operand fields through decode, next-word fetch and memory read
// over a simplified-Wishbone read port; skip mode only steps PC past next-words.
module dcpu16_opfetch #(
    parameter int DW = 16,
    parameter int AW = 16,
    parameter int NOPS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 start,
    input  logic                 skip,
    input  logic [6*NOPS-1:0]    ea,
    input  logic [DW*NOPS-1:0]   rrd,
    input  logic [AW-1:0]        pc_in,
    input  logic [AW-1:0]        sp_in,
    input  logic [DW-1:0]        reg_o,
    output logic [AW-1:0]        ab_adr,
    output logic                 ab_stb,
    output logic                 ab_wre,
    input  logic [DW-1:0]        ab_dti,
    input  logic                 ab_ack,
    output logic [DW*NOPS-1:0]   opr,
    output logic [AW*NOPS-1:0]   opa,
    output logic [NOPS-1:0]      opm,
    output logic [AW-1:0]        pc_out,
    output logic [AW-1:0]        sp_out,
    output logic                 busy,
    output logic                 done
);
    localparam logic [2:0] S_IDLE = 3'd0, S_DEC = 3'd1, S_NXT = 3'd2, S_MRD = 3'd3, S_DONE = 3'd4;
    localparam int KW = NOPS > 1 ? $clog2(NOPS) : 1;

    logic [2:0]    state, fin;
    logic [KW-1:0] k, kn;
    logic [AW-1:0] pc, sp, mem_adr, nadr;
    logic          skp, last, is_nw, is_mem;
    logic [5:0]    fld;
    logic [DW-1:0] rv, imm, nsum;
    logic [5:0]    fa [NOPS];
    logic [DW-1:0] ra [NOPS];
    logic [DW-1:0] opr_r [NOPS];
    logic [AW-1:0] opa_r [NOPS];

    for (genvar g = 0; g < NOPS; g++) begin : g_op
        assign fa[g] = ea[6*g +: 6];
        assign ra[g] = rrd[DW*g +: DW];
        assign opr[DW*g +: DW] = opr_r[g];
        assign opa[AW*g +: AW] = opa_r[g];
    end

    assign fld = fa[k];
    assign rv = ra[k];
    assign last = k == KW'(NOPS - 1);
    assign kn = last ? '0 : k + KW'(1);
    assign fin = last ? S_DONE : S_DEC;
    // next-word fields: 0x10-0x17, 0x1e, 0x1f
    assign is_nw = fld[5:3] == 3'b010 || fld[5:1] == 5'b01111;
    // memory fields without next-word: [reg], POP, PEEK, PUSH
    assign is_mem = fld[5:3] == 3'b001 || (fld[5:2] == 4'b0110 && fld[1:0] != 2'b11);
    assign mem_adr = fld[4] ? (fld[1] ? sp - AW'(1) : sp) : rv[AW-1:0];
    assign imm = fld[5] ? DW'(fld[4:0]) : !fld[4] ? rv : fld[2:0] == 3'd3 ? DW'(sp) :
                 fld[2:0] == 3'd4 ? DW'(pc) : reg_o;
    assign nsum = ab_dti + rv;
    assign nadr = fld[3] ? ab_dti[AW-1:0] : nsum[AW-1:0];
    assign busy = state != S_IDLE;
    assign ab_wre = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            k <= '0;
            pc <= '0;
            sp <= '0;
            skp <= 1'b0;
            ab_stb <= 1'b0;
            ab_adr <= '0;
            done <= 1'b0;
            pc_out <= '0;
            sp_out <= '0;
            opm <= '0;
            for (int i = 0; i < NOPS; i++) begin
                opr_r[i] <= '0;
                opa_r[i] <= '0;
            end
        end else if (ena) begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state <= S_DEC;
                    k <= '0;
                    pc <= pc_in;
                    sp <= sp_in;
                    skp <= skip;
                end
                S_DEC: begin
                    opr_r[k] <= '0;
                    opa_r[k] <= '0;
                    opm[k] <= 1'b0;
                    if (skp || !(is_nw || is_mem)) begin
                        if (skp && is_nw) pc <= pc + AW'(1);
                        if (!skp) opr_r[k] <= imm;
                        state <= fin;
                        k <= kn;
                    end else if (is_nw) begin
                        state <= S_NXT;
                        ab_stb <= 1'b1;
                        ab_adr <= pc;
                    end else begin
                        state <= S_MRD;
                        ab_stb <= 1'b1;
                        ab_adr <= mem_adr;
                        if (fld == 6'h1a) sp <= sp - AW'(1);
                    end
                end
                S_NXT: if (ab_stb && ab_ack) begin
                    pc <= pc + AW'(1);
                    if (fld == 6'h1f) begin
                        opr_r[k] <= ab_dti;
                        ab_stb <= 1'b0;
                        state <= fin;
                        k <= kn;
                    end else begin
                        ab_adr <= nadr;
                        state <= S_MRD;
                    end
                end
                S_MRD: if (ab_stb && ab_ack) begin
                    opr_r[k] <= ab_dti;
                    opa_r[k] <= ab_adr;
                    opm[k] <= 1'b1;
                    ab_stb <= 1'b0;
                    state <= fin;
                    k <= kn;
                    if (fld == 6'h18) sp <= sp + AW'(1);
                end
                S_DONE: begin
                    done <= 1'b1;
                    pc_out <= pc;
                    sp_out <= sp;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcpu16_opfetch.sv
// tb_dcpu16_opfetch: scoreboard bench; a field-by-field reference model predicts each
// instruction's results and bus addresses, a negedge monitor compares them when done pulses.
module tb_dcpu16_opfetch;
    localparam int NOPS = 2;

    logic clk = 0, rst = 0, ena = 1, start = 0, skip = 0, ab_ack = 0;
    logic [6*NOPS-1:0] ea = '0;
    logic [16*NOPS-1:0] rrd = '0;
    logic [15:0] pc_in = 0, sp_in = 0, reg_o = 0, ab_dti = 0;
    logic [15:0] ab_adr, pc_out, sp_out;
    logic ab_stb, ab_wre, busy, done;
    logic [16*NOPS-1:0] opr, opa;
    logic [NOPS-1:0] opm;

    dcpu16_opfetch #(.DW(16), .AW(16), .NOPS(NOPS)) dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .skip(skip), .ea(ea), .rrd(rrd),
        .pc_in(pc_in), .sp_in(sp_in), .reg_o(reg_o), .ab_adr(ab_adr), .ab_stb(ab_stb),
        .ab_wre(ab_wre), .ab_dti(ab_dti), .ab_ack(ab_ack), .opr(opr), .opa(opa), .opm(opm),
        .pc_out(pc_out), .sp_out(sp_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16*NOPS-1:0] opr;
        logic [16*NOPS-1:0] opa;
        logic [NOPS-1:0] opm;
        logic [15:0] pc, sp;
        int nacc;
    } exp_t;

    logic [15:0] mem [65536];
    exp_t exp_q[$];
    logic [15:0] exp_adr[$], act_adr[$];
    int pass_n = 0, tot = 0;
    int mode = 0, wlen = 0, wcnt = 0;
    logic ack_force = 0;
    int lat = 0, waits = 0, acc = 0, dn = 0;
    bit running = 0, hold = 0;
    logic [15:0] hold_adr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        tot++;
        if (act === want) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, want);
    endtask

    // Reference: walk fields in order with plain arithmetic on a working PC/SP.
    task automatic model(input logic s, input logic [6*NOPS-1:0] e, input logic [16*NOPS-1:0] r,
                         input logic [15:0] p0, input logic [15:0] s0, input logic [15:0] ro);
        exp_t x;
        logic [15:0] p, sp, v, a, nw, val;
        logic [5:0] f;
        bit rd;
        p = p0; sp = s0;
        x.opr = '0; x.opa = '0; x.opm = '0; x.nacc = 0;
        for (int i = 0; i < NOPS; i++) begin
            f = e[6*i +: 6]; v = r[16*i +: 16]; rd = 0; val = 0; a = 0;
            if (s) begin
                if ((f >= 6'h10 && f <= 6'h17) || f == 6'h1e || f == 6'h1f) p = p + 1;
                continue;
            end
            if (f < 8) val = v;
            else if (f < 16) begin a = v; rd = 1; end
            else if (f < 24 || f == 30 || f == 31) begin
                exp_adr.push_back(p); nw = mem[p]; p = p + 1; x.nacc++;
                if (f == 31) val = nw;
                else begin a = (f == 30) ? nw : 16'(nw + v); rd = 1; end
            end
            else if (f == 24) begin a = sp; sp = sp + 1; rd = 1; end
            else if (f == 25) begin a = sp; rd = 1; end
            else if (f == 26) begin sp = sp - 1; a = sp; rd = 1; end
            else if (f == 27) val = sp;
            else if (f == 28) val = p;
            else if (f == 29) val = ro;
            else val = 16'(f - 6'd32);
            if (rd) begin
                exp_adr.push_back(a); val = mem[a];
                x.opa[16*i +: 16] = a; x.opm[i] = 1'b1; x.nacc++;
            end
            x.opr[16*i +: 16] = val;
        end
        x.pc = p; x.sp = sp;
        exp_q.push_back(x);
    endtask

    // Bus responder: mode 0 zero-wait, 1 fixed wlen waits, 2 random waits + ena stalls, 3 forced ack.
    always @(posedge clk) begin
        #1;
        ab_dti = mem[ab_adr];
        if (mode == 3) begin ena = 1; ab_ack = ack_force; end
        else if (mode == 2) begin
            ena = $urandom_range(0, 5) != 0;
            ab_ack = ab_stb ? $urandom_range(0, 2) == 0 : 1'($urandom_range(0, 1));
        end else if (mode == 1) begin
            ena = 1;
            if (!ab_stb) begin ab_ack = 0; wcnt = 0; end
            else if (wcnt >= wlen) begin ab_ack = 1; wcnt = 0; end
            else begin ab_ack = 0; wcnt++; end
        end else begin ena = 1; ab_ack = ab_stb; end
    end

    // Monitor: values seen here are what the DUT samples at the coming edge.
    always @(negedge clk) begin
        exp_t x;
        if (done && running) begin
            running = 0; dn++;
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                x = exp_q.pop_front();
                chk("opr", opr, x.opr);
                chk("opa", opa, x.opa);
                chk("opm", opm, x.opm);
                chk("pc_out", pc_out, x.pc);
                chk("sp_out", sp_out, x.sp);
                chk("bus_count", act_adr.size(), x.nacc);
                for (int i = 0; i < x.nacc; i++)
                    chk("bus_adr", i < act_adr.size() ? act_adr[i] : 16'hxxxx, exp_adr.pop_front());
                chk("latency", lat, NOPS + 1 + x.nacc + waits);
            end
            act_adr.delete(); waits = 0;
        end
        if (hold) begin
            chk("stb_hold", ab_stb, 1);
            chk("adr_hold", ab_adr, hold_adr);
        end
        hold = 0;
        if (!rst) begin running = 0; act_adr.delete(); waits = 0; end
        else begin
            hold = ab_stb && !(ena && ab_ack);
            hold_adr = ab_adr;
            if (ena) begin
                if (running) lat++;
                if (start && !busy) begin running = 1; lat = 0; acc++; end
                if (ab_stb) begin
                    if (ab_ack) act_adr.push_back(ab_adr);
                    else waits++;
                end
            end
        end
    end

    task automatic issue(input logic s, input logic [6*NOPS-1:0] e, input logic [16*NOPS-1:0] r,
                         input logic [15:0] p, input logic [15:0] sp, input logic [15:0] ro);
        int a0, d0, t;
        a0 = acc; d0 = dn;
        @(posedge clk); #1;
        ea = e; rrd = r; pc_in = p; sp_in = sp; reg_o = ro; skip = s; start = 1;
        model(s, e, r, p, sp, ro);
        t = 0;
        while (acc == a0 && t < 100) begin @(posedge clk); #1; t++; end
        start = 0;
        if (acc == a0) chk("start_timeout", 0, 1);
        t = 0;
        while (dn == d0 && t < 2000) begin
            @(posedge clk); #1; t++;
            if (dn == d0) begin
                start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
                skip = 1'($urandom);
            end
        end
        start = 0;
        if (dn == d0) begin
            chk("done_timeout", 0, 1);
            exp_q.delete(); exp_adr.delete();
        end
    endtask

    initial begin
        logic [6*NOPS-1:0] e;
        logic [16*NOPS-1:0] r;
        logic [15:0] p, sp;
        int t;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 40503 + 7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_opr", opr, 0); chk("rst_opa", opa, 0); chk("rst_opm", opm, 0);
        chk("rst_pc_out", pc_out, 0); chk("rst_sp_out", sp_out, 0); chk("rst_adr", ab_adr, 0);
        chk("rst_stb", ab_stb, 0); chk("rst_done", done, 0); chk("rst_busy", busy, 0);
        chk("wre", ab_wre, 0);
        @(posedge clk); #1; rst = 1;

        mode = 0;
        issue(0, {6'h21, 6'h00}, {16'h0, 16'h1234}, 16'h0200, 16'h1000, 16'h0);
        mem[16'h0100] = 16'h0005; mem[16'h0015] = 16'hBEEF;
        issue(0, {6'h20, 6'h11}, {16'h0, 16'h0010}, 16'h0100, 16'h2000, 16'h0);
        issue(0, {6'h18, 6'h1a}, {16'h1111, 16'h2222}, 16'h0400, 16'h0000, 16'h0);
        mode = 1; wlen = 3;
        issue(0, {6'h22, 6'h1f}, {16'h0, 16'h0}, 16'h0300, 16'h0, 16'h0);
        mode = 0;
        issue(1, {6'h1f, 6'h1e}, {16'h5555, 16'h6666}, 16'hFFFF, 16'h1234, 16'h0);
        issue(0, {6'h1d, 6'h1c}, {16'h0, 16'h0}, 16'h0777, 16'h0, 16'hABCD);

        // abort a memory read by reset, then send a stray ack
        mode = 3; ack_force = 0;
        @(posedge clk); #1;
        ea = {6'h20, 6'h08}; rrd = {16'h0, 16'h0040}; skip = 0; start = 1;
        @(posedge clk); #1; start = 0;
        t = 0;
        while (!ab_stb && t < 20) begin @(posedge clk); #1; t++; end
        chk("abort_setup_stb", ab_stb, 1);
        @(posedge clk); #1; rst = 0;
        @(posedge clk); #1; rst = 1; ack_force = 1;
        @(negedge clk);
        chk("abort_stb", ab_stb, 0); chk("abort_busy", busy, 0);
        @(posedge clk); #1; ack_force = 0;
        @(negedge clk);
        chk("late_ack_stb", ab_stb, 0); chk("late_ack_busy", busy, 0); chk("late_ack_done", done, 0);
        mode = 0;
        issue(0, {6'h09, 6'h19}, {16'h0123, 16'h0}, 16'h0010, 16'h8000, 16'h0);

        for (int n = 0; n < 200; n++) begin
            mode = n % 3; wlen = $urandom_range(0, 2);
            for (int i = 0; i < NOPS; i++) e[6*i +: 6] = 6'($urandom_range(0, 63));
            r = {16'($urandom), 16'($urandom)};
            p = n % 7 == 0 ? 16'hFFFF : 16'($urandom);
            sp = n % 5 == 0 ? 16'h0000 : n % 5 == 1 ? 16'hFFFF : 16'($urandom);
            issue($urandom_range(0, 4) == 0, e, r, p, sp, 16'($urandom));
        end
        mode = 0;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_n, tot);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
